noc_flit_packetizer: RTL



---
 rtl/noc_flit_packetizer_if.sv | 44 ++++
 rtl/noc_flit_packetizer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/noc_flit_packetizer_if.sv
// rtl/noc_flit_packetizer_if.sv - descriptor, payload, flit and credit bundle for noc_flit_packetizer (optional NOC_PKT_PARITY_EN)
interface noc_flit_packetizer_if #(
    parameter int COORD_W = 30,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 4
);
    logic               msg_valid;
    logic               msg_ready;
    logic [COORD_W-1:0] msg_dest_x;
    logic [COORD_W-1:0] msg_dest_y;
    logic [LEN_W-1:0]   msg_len;
    logic               pay_valid;
    logic               pay_ready;
    logic [DATA_W-1:0]  pay_data;
    logic               flit_valid;
    logic [1:0]         flit_type;
    logic [DATA_W-1:0]  flit_data;
    logic               credit_in;
    logic               credit_err;
    logic               busy;
`ifdef NOC_PKT_PARITY_EN
    logic               flit_parity;
`endif

    modport master (
        output msg_valid, msg_dest_x, msg_dest_y, msg_len,
        output pay_valid, pay_data, credit_in,
        input  msg_ready, pay_ready, flit_valid, flit_type, flit_data,
        input  credit_err, busy
`ifdef NOC_PKT_PARITY_EN
        , input flit_parity
`endif
    );

    modport slave (
        input  msg_valid, msg_dest_x, msg_dest_y, msg_len,
        input  pay_valid, pay_data, credit_in,
        output msg_ready, pay_ready, flit_valid, flit_type, flit_data,
        output credit_err, busy
`ifdef NOC_PKT_PARITY_EN
        , output flit_parity
`endif
    );
endinterface

// File: rtl/noc_flit_packetizer.sv
// rtl/noc_flit_packetizer.sv - credit-flow packetizer: descriptor + payload words to head/body/tail flits (optional NOC_PKT_PARITY_EN)
module noc_flit_packetizer #(
    parameter int COORD_W = 30,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4
) (
    input logic                 clk,
    input logic                 rst,
    noc_flit_packetizer_if.slave bus
);
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COORD_W-1:0] r_dest_x;
    logic [COORD_W-1:0] r_dest_y;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_credits;
    logic               r_credit_err;
    logic               r_flit_valid;
    logic [1:0]         r_flit_type;
    logic [DATA_W-1:0]  r_flit_data;
    logic               w_have_credit;
    logic               w_accept;
    logic               w_send_head;
    logic               w_send_pay;
    logic               w_send;
    logic [1:0]         w_type_nxt;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [DATA_W-1:0]  w_head_data;

    assign w_have_credit = (r_credits != '0);
    assign w_accept      = (r_state == S_IDLE) && bus.msg_valid;
    assign w_send_head   = (r_state == S_HEAD) && w_have_credit;
    assign w_send_pay    = (r_state == S_PAYLOAD) && w_have_credit && bus.pay_valid;
    assign w_send        = w_send_head | w_send_pay;

    // Head flit carries the route header in the low bits, zero above
    always_comb begin
        w_head_data = '0;
        w_head_data[2*COORD_W+LEN_W-1:0] = {r_len, r_dest_y, r_dest_x};
    end

    // Type and data of the flit that the current edge would emit
    always_comb begin
        w_type_nxt = 2'b00;
        w_data_nxt = bus.pay_data;
        if (w_send_head) begin
            w_type_nxt = (r_len == '0) ? 2'b11 : 2'b01;
            w_data_nxt = w_head_data;
        end else if (r_remaining == LEN_W'(1)) begin
            w_type_nxt = 2'b10;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: a head-only packet returns straight to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.msg_valid) w_state_nxt = S_HEAD;
            S_HEAD:    if (w_have_credit) w_state_nxt = (r_len == '0) ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: if (w_send_pay && (r_remaining == LEN_W'(1))) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Descriptor capture; msg_* are only looked at while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dest_x <= '0;
            r_dest_y <= '0;
            r_len    <= '0;
        end else if (w_accept) begin
            r_dest_x <= bus.msg_dest_x;
            r_dest_y <= bus.msg_dest_y;
            r_len    <= bus.msg_len;
        end
    end

    // Payload flits still owed for the current packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_remaining <= '0;
        else if (w_send_head) r_remaining <= r_len;
        else if (w_send_pay)  r_remaining <= r_remaining - LEN_W'(1);
    end

    // Registered flit output; type/data hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flit_valid <= 1'b0;
            r_flit_type  <= 2'b00;
            r_flit_data  <= '0;
        end else begin
            r_flit_valid <= w_send;
            if (w_send) begin
                r_flit_type <= w_type_nxt;
                r_flit_data <= w_data_nxt;
            end
        end
    end

    // Credit counter; a return with no room left saturates and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits    <= CREDITS_MAX;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_send, bus.credit_in})
                2'b10: r_credits <= r_credits - CNT_W'(1);
                2'b01: begin
                    if (r_credits == CREDITS_MAX) r_credit_err <= 1'b1;
                    else                          r_credits    <= r_credits + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef NOC_PKT_PARITY_EN
    logic r_flit_parity;

    // Even parity over the flit, registered with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_flit_parity <= 1'b0;
        else if (w_send) r_flit_parity <= ^{w_type_nxt, w_data_nxt};
    end

    assign bus.flit_parity = r_flit_parity;
`endif

    assign bus.msg_ready  = (r_state == S_IDLE);
    assign bus.pay_ready  = (r_state == S_PAYLOAD) && w_have_credit;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.flit_valid = r_flit_valid;
    assign bus.flit_type  = r_flit_type;
    assign bus.flit_data  = r_flit_data;
    assign bus.credit_err = r_credit_err;
endmodule
